// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32 decode stage (OP/OP-IMM/LUI), one-entry output register; illegal checks under DECODE_ILLEGAL_CHECK_EN
module decode_stage #(
    parameter int XLEN         = 32,
    parameter bit NOP_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            src_sel,
    output logic [XLEN-1:0] immediate,
    output logic            alu_en,
    output logic            reg_we,
    output logic            dec_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // ADDI x0,x0,0 has every decoded field zero, so both reset flavours leave the outputs at 0.
    localparam logic [31:0] RST_WORD = NOP_ON_RESET ? 32'h0000_0013 : 32'h0000_0000;

    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [2:0]      r_f3;
    logic [6:0]      r_f7;
    logic            r_src, r_alu_en, r_reg_we, r_illegal, r_valid;
    logic [XLEN-1:0] r_imm;

    logic [6:0]      w_opcode, w_f7_raw, w_f7;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic            w_src, w_supported, w_illegal, w_alu_en, w_reg_we, w_accept;
    logic [XLEN-1:0] w_imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic            w_f7_ok;
`endif

    assign w_opcode = instr[6:0];
    assign w_f7_raw = instr[31:25];

    always_comb begin
        w_rs1       = instr[19:15];
        w_rs2       = 5'd0;
        w_rd        = instr[11:7];
        w_f3        = instr[14:12];
        w_f7        = 7'd0;
        w_src       = 1'b0;
        w_imm       = '0;
        w_supported = 1'b0;
`ifdef DECODE_ILLEGAL_CHECK_EN
        w_f7_ok     = 1'b1;
`endif
        case (w_opcode)
            OPC_OP: begin
                w_supported = 1'b1;
                w_rs2       = instr[24:20];
                w_src       = 1'b1;
                w_f7        = w_f7_raw;
`ifdef DECODE_ILLEGAL_CHECK_EN
                w_f7_ok = (w_f7_raw == 7'd0) ||
                          ((w_f7_raw == F7_ALT) &&
                           ((instr[14:12] == F3_ADD_SUB) || (instr[14:12] == F3_SRL_SRA)));
`endif
            end
            OPC_OP_IMM: begin
                w_supported = 1'b1;
                w_imm       = {{20{instr[31]}}, instr[31:20]};
                if ((instr[14:12] == F3_SLL) || (instr[14:12] == F3_SRL_SRA)) begin
                    w_f7  = w_f7_raw;
                    w_imm = {27'd0, instr[24:20]};
`ifdef DECODE_ILLEGAL_CHECK_EN
                    w_f7_ok = (w_f7_raw == 7'd0) ||
                              ((w_f7_raw == F7_ALT) && (instr[14:12] == F3_SRL_SRA));
`endif
                end
            end
            OPC_LUI: begin
                w_supported = 1'b1;
                w_f3        = 3'd0;
                w_rs1       = 5'd0;
                w_imm       = {instr[31:12], 12'd0};
            end
            default: ;
        endcase
    end

    // Low opcode bits other than 2'b11 never match a supported opcode, so they fall out as unsupported.
`ifdef DECODE_ILLEGAL_CHECK_EN
    assign w_illegal = !w_supported || !w_f7_ok;
`else
    assign w_illegal = 1'b0;
`endif
    assign w_alu_en = w_supported && !w_illegal;
    assign w_reg_we = w_alu_en && (w_rd != 5'd0);

    assign instr_ready = !r_valid || dec_ready;
    assign w_accept    = instr_valid && instr_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_rs1     <= RST_WORD[19:15];
            r_rs2     <= 5'd0;
            r_rd      <= RST_WORD[11:7];
            r_f3      <= RST_WORD[14:12];
            r_f7      <= 7'd0;
            r_src     <= 1'b0;
            r_imm     <= {{(XLEN-12){RST_WORD[31]}}, RST_WORD[31:20]};
            r_alu_en  <= 1'b0;
            r_reg_we  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_f3      <= w_f3;
            r_f7      <= w_f7;
            r_src     <= w_src;
            r_imm     <= w_imm;
            r_alu_en  <= w_alu_en;
            r_reg_we  <= w_reg_we;
            r_illegal <= w_illegal;
        end else if (dec_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign dec_valid   = r_valid;
    assign rs1_addr    = r_rs1;
    assign rs2_addr    = r_rs2;
    assign rd_addr     = r_rd;
    assign funct3      = r_f3;
    assign funct7      = r_f7;
    assign src_sel     = r_src;
    assign immediate   = r_imm;
    assign alu_en      = r_alu_en;
    assign reg_we      = r_reg_we;
    assign dec_illegal = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed checks for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, instr_valid, instr_ready, dec_valid, dec_ready;
    logic [31:0] instr, immediate;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        src_sel, alu_en, reg_we, dec_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .funct3(funct3), .funct7(funct7), .src_sel(src_sel),
        .immediate(immediate), .alu_en(alu_en), .reg_we(reg_we),
        .dec_illegal(dec_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0; instr = 32'h0;
        cyc(); cyc();
        chk("rst_valid", dec_valid, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_illegal", dec_illegal, 0);
        chk("rst_imm", immediate, 0);
        chk("rst_rd", rd_addr, 0);
        chk("rst_ready", instr_ready, 1);

        // ADDI x1,x0,5
        rst_n = 1'b1; dec_ready = 1'b1; instr_valid = 1'b1; instr = 32'h0050_0093;
        cyc();
        chk("addi_valid", dec_valid, 1);
        chk("addi_rd", rd_addr, 1);
        chk("addi_rs1", rs1_addr, 0);
        chk("addi_f3", funct3, 0);
        chk("addi_f7", funct7, 0);
        chk("addi_src", src_sel, 0);
        chk("addi_imm", immediate, 5);
        chk("addi_alu_en", alu_en, 1);
        chk("addi_reg_we", reg_we, 1);

        // ADDI x1,x0,-1024
        instr = 32'hC000_0093;
        cyc();
        chk("addineg_imm", immediate, 32'hFFFF_FC00);
        chk("addineg_f7", funct7, 0);
        chk("addineg_valid", dec_valid, 1);

        // SUB x3,x1,x2 then SRAI x5,x6,3 back to back
        instr = 32'h4020_81B3;
        cyc();
        chk("sub_f7", funct7, 7'b0100000);
        chk("sub_src", src_sel, 1);
        chk("sub_rs2", rs2_addr, 2);
        chk("sub_rs1", rs1_addr, 1);
        chk("sub_rd", rd_addr, 3);
        chk("sub_ready", instr_ready, 1);
        instr = 32'h4033_5293;
        cyc();
        chk("srai_f3", funct3, 3'b101);
        chk("srai_f7", funct7, 7'b0100000);
        chk("srai_imm", immediate, 3);
        chk("srai_src", src_sel, 0);
        chk("srai_rs2", rs2_addr, 0);
        chk("srai_rd", rd_addr, 5);
        chk("srai_ready", instr_ready, 1);

        // LUI x7,0x12345 held for 3 cycles while another instruction waits
        instr = 32'h1234_53B7;
        cyc();
        chk("lui_imm", immediate, 32'h1234_5000);
        chk("lui_rd", rd_addr, 7);
        chk("lui_rs1", rs1_addr, 0);
        chk("lui_f3", funct3, 0);
        dec_ready = 1'b0; instr = 32'h0050_0093;
        #1;
        chk("hold_ready0", instr_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_valid", dec_valid, 1);
            chk("hold_imm", immediate, 32'h1234_5000);
            chk("hold_rd", rd_addr, 7);
            chk("hold_ready", instr_ready, 0);
        end
        dec_ready = 1'b1; instr_valid = 1'b0;
        #1;
        chk("release_ready", instr_ready, 1);
        cyc();
        chk("drain_valid", dec_valid, 0);

        // ADDI x0,x0,5: ALU runs, no writeback
        instr_valid = 1'b1; instr = 32'h0050_0013;
        cyc();
        chk("x0_alu_en", alu_en, 1);
        chk("x0_reg_we", reg_we, 0);

        // Unsupported opcode, bad OP funct7, SLLI with alternate funct7
        instr = 32'h0000_007F;
        cyc();
        chk("bad_opc_valid", dec_valid, 1);
        chk("bad_opc_alu_en", alu_en, 0);
        chk("bad_opc_reg_we", reg_we, 0);
`ifdef DECODE_ILLEGAL_CHECK_EN
        chk("bad_opc_illegal", dec_illegal, 1);
`else
        chk("bad_opc_illegal", dec_illegal, 0);
`endif
        instr = 32'h4010_9093;
        cyc();
`ifdef DECODE_ILLEGAL_CHECK_EN
        chk("slli_alt_illegal", dec_illegal, 1);
        chk("slli_alt_alu_en", alu_en, 0);
`else
        chk("slli_alt_illegal", dec_illegal, 0);
        chk("slli_alt_alu_en", alu_en, 1);
        chk("slli_alt_f7", funct7, 7'b0100000);
        chk("slli_alt_imm", immediate, 1);
`endif
        instr = 32'hFE00_81B3;
        cyc();
`ifdef DECODE_ILLEGAL_CHECK_EN
        chk("bad_f7_illegal", dec_illegal, 1);
        chk("bad_f7_alu_en", alu_en, 0);
        chk("bad_f7_reg_we", reg_we, 0);
`else
        chk("bad_f7_illegal", dec_illegal, 0);
        chk("bad_f7_alu_en", alu_en, 1);
        chk("bad_f7_reg_we", reg_we, 1);
        chk("bad_f7_f7", funct7, 7'h7F);
`endif

        // Flush with a held bundle and an offered instruction
        dec_ready = 1'b0; flush = 1'b1; instr = 32'h00A0_0113;
        #1;
        chk("flush_ready", instr_ready, 0);
        cyc();
        chk("flush_valid", dec_valid, 0);
        flush = 1'b0; instr_valid = 1'b0;
        cyc();
        chk("flush_dropped", dec_valid, 0);

        // Flush wins over an accept
        instr_valid = 1'b1; flush = 1'b1;
        #1;
        chk("flush_acc_ready", instr_ready, 1);
        cyc();
        chk("flush_acc_valid", dec_valid, 0);

        // Reset while a bundle is held
        flush = 1'b0;
        cyc();
        chk("pre_rst_valid", dec_valid, 1);
        chk("pre_rst_rd", rd_addr, 2);
        chk("pre_rst_imm", immediate, 10);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_valid", dec_valid, 0);
        chk("mid_rst_rd", rd_addr, 0);
        chk("mid_rst_imm", immediate, 0);
        chk("mid_rst_alu_en", alu_en, 0);
        chk("mid_rst_reg_we", reg_we, 0);
        chk("mid_rst_f3", funct3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
